sort_stream_loader: RTL and testbench

- Front-end/back-end sequencer for the in-memory exchange sorter.
- Accepts K unsorted words over a valid/ready stream and writes them to memory addresses 0..K-1.
- Pulses the sorter's start input, then waits for its done flag.
- Streams the sorted words back out in address order over a valid/ready stream. While the sorter runs, the block owns no memory port.

---
 rtl/sort_stream_loader.sv | 106 ++++++++++
 tb/tb_sort_stream_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_stream_loader.sv
// Sequencer around an in-place exchange sorter: streams K words into memory,
// kicks the sorter, waits for completion, then streams the sorted words back out.
module sort_stream_loader #(
    parameter int K  = 8,
    parameter int N  = 8,
    parameter int AW = $clog2(K)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [N-1:0]  in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [N-1:0]  out_data,
    input  logic          out_ready,
    output logic          mem_sel,
    output logic [AW-1:0] mem_addr,
    output logic [N-1:0]  mem_wdata,
    output logic          mem_we,
    input  logic [N-1:0]  mem_rdata,
    output logic          sort_start,
    input  logic          sort_done,
    output logic          busy
);

    typedef enum logic [1:0] {LOAD, START, WAIT, UNLOAD} state_t;

    localparam logic [AW-1:0] LAST = AW'(K - 1);

    state_t        state_reg, state_next;
    logic [AW-1:0] cnt_reg, cnt_next;
    logic          in_ready_reg, out_valid_reg, mem_sel_reg, sort_start_reg, busy_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            LOAD: begin
                if (in_valid) begin
                    if (cnt_reg == LAST) begin
                        state_next = START;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            START: state_next = WAIT;
            WAIT: begin
                // Done pulses are only honoured here; anywhere else they are stale or spurious.
                if (sort_done) begin
                    state_next = UNLOAD;
                    cnt_next   = '0;
                end
            end
            UNLOAD: begin
                if (out_ready) begin
                    if (cnt_reg == LAST) begin
                        state_next = LOAD;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = LOAD;
                cnt_next   = '0;
            end
        endcase
    end

    // Handshake and control flags are registered decodes of the next state,
    // so they never depend combinationally on in_valid or out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= LOAD;
            cnt_reg        <= '0;
            in_ready_reg   <= 1'b1;
            out_valid_reg  <= 1'b0;
            mem_sel_reg    <= 1'b1;
            sort_start_reg <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            in_ready_reg   <= (state_next == LOAD);
            out_valid_reg  <= (state_next == UNLOAD);
            mem_sel_reg    <= (state_next == LOAD) || (state_next == UNLOAD);
            sort_start_reg <= (state_next == START);
            busy_reg       <= !((state_next == LOAD) && (cnt_next == '0));
        end
    end

    assign in_ready   = in_ready_reg;
    assign out_valid  = out_valid_reg;
    assign mem_sel    = mem_sel_reg;
    assign sort_start = sort_start_reg;
    assign busy       = busy_reg;

    assign mem_addr  = cnt_reg;
    assign mem_we    = (state_reg == LOAD) && in_valid;
    assign mem_wdata = (state_reg == LOAD) ? in_data : '0;
    assign out_data  = (state_reg == UNLOAD) ? mem_rdata : '0;

endmodule

// File: tb/tb_sort_stream_loader.sv
// Bench for sort_stream_loader: memory + sorter model, vector table of batches,
// scoreboard queue of expected sorted words, plus reset and spurious-done sequences.
module tb_sort_stream_loader;

    localparam int K  = 8;
    localparam int N  = 8;
    localparam int AW = 3;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [N-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic [N-1:0]  out_data;
    logic          out_ready;
    logic          mem_sel;
    logic [AW-1:0] mem_addr;
    logic [N-1:0]  mem_wdata;
    logic          mem_we;
    logic [N-1:0]  mem_rdata;
    logic          sort_start;
    logic          sort_done;
    logic          busy;

    sort_stream_loader #(.K(K), .N(N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .sort_start(sort_start), .sort_done(sort_done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef logic [7:0] arr_t [K];
    typedef struct {
        arr_t din;
        arr_t dout;
        int   in_gap;
        int   out_stall;
        bit   hold_valid;
        bit   spur;
    } vec_t;

    vec_t       vecs [5];
    arr_t       mem;
    logic       model_done;
    logic       spur_done;
    int         timer;
    int         n_start;
    int         exp_starts;
    logic [7:0] exp_q [$];
    int         n_cmp;
    int         n_err;

    assign mem_rdata = mem[mem_addr];
    assign sort_done = model_done | spur_done;

    function automatic arr_t sort8(input arr_t a);
        arr_t r = a;
        logic [7:0] t;
        for (int p = 0; p < K - 1; p++)
            for (int q = 0; q < K - 1 - p; q++)
                if (r[q] > r[q+1]) begin
                    t = r[q]; r[q] = r[q+1]; r[q+1] = t;
                end
        return r;
    endfunction

    // Memory plus a sorter that sorts in place a few cycles after its start pulse.
    initial n_start = 0;
    always @(posedge clk) begin
        if (sort_start) n_start <= n_start + 1;
        if (rst) begin
            timer      <= 0;
            model_done <= 1'b0;
        end else begin
            model_done <= 1'b0;
            if (mem_sel && mem_we) mem[mem_addr] <= mem_wdata;
            if (sort_start) timer <= 6;
            else if (timer == 1) begin
                mem        <= sort8(mem);
                model_done <= 1'b1;
                timer      <= 0;
            end else if (timer != 0) timer <= timer - 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_batch(input int v);
        int i = 0;
        int gap_cnt = 0;
        int cyc = 0;
        while (i < K && cyc < 200) begin
            in_valid  = (gap_cnt == 0);
            in_data   = in_valid ? vecs[v].din[i] : 8'($urandom);
            spur_done = vecs[v].spur && (i == 3);
            #1;
            chk("load_in_ready", in_ready, 1);
            chk("load_busy", busy, (i != 0));
            chk("load_we", mem_we, in_valid);
            chk("load_sel", mem_sel, 1);
            chk("load_no_start", sort_start, 0);
            if (in_valid) begin
                chk("load_addr", mem_addr, i);
                chk("load_wdata", mem_wdata, vecs[v].din[i]);
                $display("load v%0d word %0d = %0d", v, i, vecs[v].din[i]);
                i++;
            end
            gap_cnt = (gap_cnt == vecs[v].in_gap) ? 0 : gap_cnt + 1;
            step();
            cyc++;
        end
        if (i < K) chk("load_timeout", i, K);
    endtask

    task automatic start_and_wait(input int v);
        int  cyc = 0;
        logic prev_done = 1'b0;
        in_valid  = vecs[v].hold_valid;
        in_data   = 8'hEE;
        spur_done = vecs[v].spur;
        #1;
        chk("start_pulse", sort_start, 1);
        chk("start_in_ready", in_ready, 0);
        chk("start_sel", mem_sel, 0);
        chk("start_we", mem_we, 0);
        chk("start_busy", busy, 1);
        step();
        spur_done = 1'b0;
        exp_starts++;
        chk("start_count", n_start, exp_starts);
        for (int k = 0; k < K; k++) exp_q.push_back(vecs[v].dout[k]);
        while (!out_valid && cyc < 100) begin
            #1;
            chk("wait_in_ready", in_ready, 0);
            chk("wait_we", mem_we, 0);
            chk("wait_no_start", sort_start, 0);
            chk("wait_sel", mem_sel, 0);
            prev_done = sort_done;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        chk("wait_out_valid", out_valid, 1);
        chk("done_latency", prev_done, 1);
    endtask

    task automatic unload(input int v, input int stop_at);
        logic [7:0] e;
        for (int j = 0; j < stop_at; j++) begin
            for (int s = 0; s < vecs[v].out_stall; s++) begin
                out_ready = 1'b0;
                spur_done = vecs[v].spur && (j == 2);
                #1;
                chk("stall_valid", out_valid, 1);
                chk("stall_addr", mem_addr, j);
                chk("stall_we", mem_we, 0);
                if (exp_q.size() > 0) chk("stall_data", out_data, exp_q[0]);
                step();
            end
            out_ready = 1'b1;
            spur_done = vecs[v].spur && (j == 2);
            #1;
            chk("unload_valid", out_valid, 1);
            chk("unload_addr", mem_addr, j);
            chk("unload_busy", busy, 1);
            chk("unload_sel", mem_sel, 1);
            if (exp_q.size() == 0) chk("scoreboard_empty", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("unload_data", out_data, e);
                $display("unload v%0d addr %0d got %0d exp %0d", v, j, out_data, e);
            end
            step();
        end
        out_ready = 1'b0;
        spur_done = 1'b0;
    endtask

    task automatic run_batch(input int v);
        load_batch(v);
        start_and_wait(v);
        unload(v, K);
        #1;
        chk("end_out_valid", out_valid, 0);
        chk("end_in_ready", in_ready, 1);
        chk("end_busy", busy, 0);
        chk("end_sel", mem_sel, 1);
        chk("end_start_count", n_start, exp_starts);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; exp_starts = 0;
        vecs[0].din = '{5, 3, 7, 1, 8, 2, 6, 4};
        vecs[0].dout = '{1, 2, 3, 4, 5, 6, 7, 8};
        vecs[0].in_gap = 0; vecs[0].out_stall = 0; vecs[0].hold_valid = 0; vecs[0].spur = 0;
        vecs[1] = vecs[0];
        vecs[1].in_gap = 1; vecs[1].hold_valid = 1;
        vecs[2] = vecs[0];
        vecs[2].out_stall = 3;
        vecs[3].din = '{8, 8, 1, 1, 2, 2, 9, 0};
        vecs[3].dout = '{0, 1, 1, 2, 2, 8, 8, 9};
        vecs[3].in_gap = 0; vecs[3].out_stall = 0; vecs[3].hold_valid = 0; vecs[3].spur = 0;
        vecs[4].din = '{255, 0, 128, 127, 1, 254, 64, 63};
        vecs[4].dout = '{0, 1, 63, 64, 127, 128, 254, 255};
        vecs[4].in_gap = 2; vecs[4].out_stall = 1; vecs[4].hold_valid = 1; vecs[4].spur = 1;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; spur_done = 1'b0;
        step(); step();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("idle_in_ready", in_ready, 1);
            chk("idle_out_valid", out_valid, 0);
            chk("idle_start", sort_start, 0);
            chk("idle_sel", mem_sel, 1);
            chk("idle_busy", busy, 0);
            chk("idle_we", mem_we, 0);
            chk("idle_addr", mem_addr, 0);
            chk("idle_wdata", mem_wdata, 0);
            step();
        end

        for (int v = 0; v < 3; v++) run_batch(v);

        // Abort mid-unload after three words have left, then run a fresh batch.
        load_batch(0);
        start_and_wait(0);
        unload(0, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_sel", mem_sel, 1);
        $display("reset mid-unload: dropped %0d pending words", exp_q.size());
        exp_q.delete();
        run_batch(3);
        run_batch(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
